// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder buffer with in-order allocate/retire, CDB completion and mispredict flush
module rob_ctrl #(
  parameter int ROB_SIZE = 32,
  parameter int ROB_SIZE_CLOG = 5,
  parameter int ISSUE_WIDTH = 2,
  parameter int RETIRE_WIDTH = 2,
  parameter int NUM_CDB = 2,
  parameter int SRC_LEN = 5,
  parameter int DATA_LEN = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic [ISSUE_WIDTH-1:0] instr_val_id,
  input  logic [ISSUE_WIDTH*SRC_LEN-1:0] rd_id,
  input  logic [ISSUE_WIDTH-1:0] nowb_id,
  output logic [ROB_SIZE_CLOG-1:0] rob_is_ptr,
  output logic rob_full,
  output logic rob_empty,
  input  logic [NUM_CDB-1:0] cdb_val,
  input  logic [NUM_CDB*ROB_SIZE_CLOG-1:0] cdb_robid,
  input  logic [NUM_CDB*DATA_LEN-1:0] cdb_data,
  input  logic [NUM_CDB-1:0] cdb_mispredict,
  output logic [RETIRE_WIDTH-1:0] val_ret,
  output logic [RETIRE_WIDTH*SRC_LEN-1:0] rd_ret,
  output logic [RETIRE_WIDTH-1:0] branch_ret,
  output logic [RETIRE_WIDTH*DATA_LEN-1:0] data_ret,
  output logic branch_clear,
  output logic [ROB_SIZE_CLOG-1:0] mispredict_tag
);
  logic [ROB_SIZE-1:0] valid, done, mispred, nowb;
  logic [SRC_LEN-1:0] rd [ROB_SIZE];
  logic [DATA_LEN-1:0] data [ROB_SIZE];
  logic [ROB_SIZE_CLOG-1:0] head, tail, flush_tag;
  logic [ROB_SIZE_CLOG:0] count, n_ret, n_alloc;
  logic [ROB_SIZE_CLOG-1:0] ret_idx [RETIRE_WIDTH];
  logic [ROB_SIZE_CLOG-1:0] alloc_idx [ISSUE_WIDTH];
  logic [RETIRE_WIDTH-1:0] ret;
  logic flush, alloc_en, ok;

  assign rob_full = count > (ROB_SIZE_CLOG+1)'(ROB_SIZE - ISSUE_WIDTH);
  assign rob_empty = count == '0;
  assign rob_is_ptr = tail;

  // Retire stops after the first not-done entry or right after a mispredicted one.
  always_comb begin
    n_ret = '0;
    flush = 1'b0;
    flush_tag = head;
    ok = 1'b1;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      ret_idx[j] = head + ROB_SIZE_CLOG'(j);
      ret[j] = ok && valid[ret_idx[j]] && done[ret_idx[j]];
      ok = ret[j] && !mispred[ret_idx[j]];
      n_ret = ret[j] ? n_ret + 1'b1 : n_ret;
      if (ret[j] && mispred[ret_idx[j]]) begin
        flush = 1'b1;
        flush_tag = ret_idx[j];
      end
    end
    alloc_en = !rob_full && !flush;
    n_alloc = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      alloc_idx[i] = tail + n_alloc[ROB_SIZE_CLOG-1:0];
      n_alloc = instr_val_id[i] ? n_alloc + 1'b1 : n_alloc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      valid <= '0;
      val_ret <= '0;
      rd_ret <= '0;
      branch_ret <= '0;
      data_ret <= '0;
      branch_clear <= 1'b0;
      mispredict_tag <= '0;
    end else begin
      for (int k = 0; k < NUM_CDB; k++)
        if (cdb_val[k] && !flush && valid[cdb_robid[k*ROB_SIZE_CLOG +: ROB_SIZE_CLOG]]) begin
          done[cdb_robid[k*ROB_SIZE_CLOG +: ROB_SIZE_CLOG]] <= 1'b1;
          mispred[cdb_robid[k*ROB_SIZE_CLOG +: ROB_SIZE_CLOG]] <= cdb_mispredict[k];
          data[cdb_robid[k*ROB_SIZE_CLOG +: ROB_SIZE_CLOG]] <= cdb_data[k*DATA_LEN +: DATA_LEN];
        end
      for (int i = 0; i < ISSUE_WIDTH; i++)
        if (alloc_en && instr_val_id[i]) begin
          valid[alloc_idx[i]] <= 1'b1;
          done[alloc_idx[i]] <= 1'b0;
          mispred[alloc_idx[i]] <= 1'b0;
          nowb[alloc_idx[i]] <= nowb_id[i];
          rd[alloc_idx[i]] <= rd_id[i*SRC_LEN +: SRC_LEN];
        end
      for (int j = 0; j < RETIRE_WIDTH; j++)
        if (ret[j]) begin
          valid[ret_idx[j]] <= 1'b0;
          rd_ret[j*SRC_LEN +: SRC_LEN] <= rd[ret_idx[j]];
          data_ret[j*DATA_LEN +: DATA_LEN] <= data[ret_idx[j]];
          branch_ret[j] <= nowb[ret_idx[j]];
        end
      val_ret <= ret;
      branch_clear <= flush;
      mispredict_tag <= flush ? flush_tag : '0;
      head <= head + n_ret[ROB_SIZE_CLOG-1:0];
      if (flush) begin
        valid <= '0;
        tail <= head + n_ret[ROB_SIZE_CLOG-1:0];
        count <= '0;
      end else begin
        tail <= alloc_en ? tail + n_alloc[ROB_SIZE_CLOG-1:0] : tail;
        count <= count + (alloc_en ? n_alloc : '0) - n_ret;
      end
    end
  end

  always_ff @(posedge clk)
    for (int a = 0; a < NUM_CDB; a++)
      for (int b = a + 1; b < NUM_CDB; b++)
        assert (rst || !(cdb_val[a] && cdb_val[b] &&
          cdb_robid[a*ROB_SIZE_CLOG +: ROB_SIZE_CLOG] == cdb_robid[b*ROB_SIZE_CLOG +: ROB_SIZE_CLOG]));
endmodule
